sram_responder: RTL and testbench

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder.sv | 122 ++++++++++++
 tb/tb_sram_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Dual-port SRAM model answering instruction fetches (two words) and data loads/stores with one cycle of latency.
// It also translates addresses, flags access errors (sticky) and counts fetches and stores.
module sram_responder #(
   parameter int WORDS_LOG2 = 14
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [63:0] inst_sram_rdata,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        err,
   output logic [31:0] err_addr,
   output logic [31:0] fetch_cnt,
   output logic [31:0] store_cnt
);
   localparam int DEPTH = 1 << WORDS_LOG2;
   typedef logic [WORDS_LOG2-1:0] idx_t;
   localparam idx_t LAST_IDX = '1;

   logic [31:0] mem [DEPTH];

   logic [63:0] inst_rdata_d, inst_rdata_q;
   logic [31:0] data_rdata_d, data_rdata_q;
   logic        err_d, err_q;
   logic [31:0] err_addr_d, err_addr_q;
   logic [31:0] fetch_cnt_d, fetch_cnt_q;
   logic [31:0] store_cnt_d, store_cnt_q;

   logic [31:0] i_pa, d_pa;
   idx_t        i_w, d_w;
   logic        i_ok, d_ok, i_err, d_err, d_rd, d_wr;

   logic unused_inst_wdata;
   assign unused_inst_wdata = ^inst_sram_wdata;

   // kseg0/kseg1 windows fold onto physical address zero.
   function automatic logic [31:0] translate(input logic [31:0] va);
      if (va[31:29] == 3'b100 || va[31:29] == 3'b101) return {3'b000, va[28:0]};
      return va;
   endfunction

   always_comb begin
      i_pa  = translate(inst_sram_addr);
      d_pa  = translate(data_sram_addr);
      i_w   = i_pa[WORDS_LOG2+1:2];
      d_w   = d_pa[WORDS_LOG2+1:2];
      i_ok  = (i_pa >> (WORDS_LOG2 + 2)) == 32'd0;
      d_ok  = (d_pa >> (WORDS_LOG2 + 2)) == 32'd0;
      d_rd  = data_sram_en && (data_sram_wen == 4'b0000);
      d_wr  = data_sram_en && (data_sram_wen != 4'b0000);
      i_err = inst_sram_en && (!i_ok || inst_sram_addr[1:0] != 2'b00 || inst_sram_wen != 4'b0000);
      d_err = data_sram_en && !d_ok;

      // NOTE: every output register has an explicit default so no latch is inferred.
      // Memory is sampled before this edge's write lands, giving read-first behaviour.
      inst_rdata_d = inst_rdata_q;
      if (inst_sram_en) begin
         inst_rdata_d = '0;
         if (i_ok) begin
            inst_rdata_d[31:0] = mem[i_w];
            if (i_w != LAST_IDX) inst_rdata_d[63:32] = mem[i_w + idx_t'(1)];
         end
      end

      data_rdata_d = data_rdata_q;
      if (d_rd) data_rdata_d = d_ok ? mem[d_w] : 32'd0;

      err_d      = err_q | i_err | d_err;
      err_addr_d = err_addr_q;
      if (!err_q) begin
         if (d_err)      err_addr_d = data_sram_addr;
         else if (i_err) err_addr_d = inst_sram_addr;
      end

      fetch_cnt_d = fetch_cnt_q;
      if (inst_sram_en && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
      store_cnt_d = store_cnt_q;
      if (d_wr && store_cnt_q != 32'hFFFF_FFFF) store_cnt_d = store_cnt_q + 32'd1;
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         err_q        <= 1'b0;
         err_addr_q   <= '0;
         fetch_cnt_q  <= '0;
         store_cnt_q  <= '0;
      end else begin
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         err_q        <= err_d;
         err_addr_q   <= err_addr_d;
         fetch_cnt_q  <= fetch_cnt_d;
         store_cnt_q  <= store_cnt_d;
      end
   end

   // NOTE: the memory array has no reset; contents survive resetn and requests are gated off instead.
   always_ff @(posedge clk) begin
      if (resetn && d_wr && d_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) mem[d_w][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   assign inst_sram_rdata = inst_rdata_q;
   assign data_sram_rdata = data_rdata_q;
   assign err             = err_q;
   assign err_addr        = err_addr_q;
   assign fetch_cnt       = fetch_cnt_q;
   assign store_cnt       = store_cnt_q;
endmodule

// File: tb/tb_sram_responder.sv
// Directed scoreboard bench for sram_responder: expected read data is queued at request time
// and compared one edge later; status outputs are checked against bench constants.
module tb_sram_responder;
   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [63:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        err;
   logic [31:0] err_addr;
   logic [31:0] fetch_cnt;
   logic [31:0] store_cnt;

   int checks   = 0;
   int failures = 0;
   logic [63:0] inst_q[$];
   logic [31:0] data_q[$];

   sram_responder #(.WORDS_LOG2(14)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .err(err), .err_addr(err_addr), .fetch_cnt(fetch_cnt), .store_cnt(store_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_sram_en = 1'b0; inst_sram_wen = 4'h0; inst_sram_addr = '0; inst_sram_wdata = '0;
      data_sram_en = 1'b0; data_sram_wen = 4'h0; data_sram_addr = '0; data_sram_wdata = '0;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [63:0] exp);
      inst_sram_en = 1'b1; inst_sram_addr = addr;
      inst_q.push_back(exp);
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] exp);
      data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = addr;
      data_q.push_back(exp);
   endtask

   task automatic store(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
      data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
   endtask

   // One clock: scoreboard entries queued for the requests driven this cycle are popped and compared.
   task automatic tick();
      logic ie, de;
      ie = inst_sram_en;
      de = data_sram_en && (data_sram_wen == 4'h0);
      @(posedge clk);
      #1;
      if (ie && inst_q.size() > 0) check("inst_rdata", inst_sram_rdata, inst_q.pop_front());
      if (de && data_q.size() > 0) check("data_rdata", {32'd0, data_sram_rdata}, {32'd0, data_q.pop_front()});
      idle_inputs();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_inst_rdata"}, inst_sram_rdata, 64'd0);
      check({tag, "_data_rdata"}, {32'd0, data_sram_rdata}, 64'd0);
      check({tag, "_err"}, {63'd0, err}, 64'd0);
      check({tag, "_err_addr"}, {32'd0, err_addr}, 64'd0);
      check({tag, "_fetch_cnt"}, {32'd0, fetch_cnt}, 64'd0);
      check({tag, "_store_cnt"}, {32'd0, store_cnt}, 64'd0);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 check_all_zero("rst_pulse");
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   initial begin
      idle_inputs();
      resetn = 1'b1;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("por");
      resetn = 1'b1;

      // Preload through the data port; a reset pulse afterwards clears the counters but not memory.
      store(32'h0000_0000, 4'hF, 32'h1111_1111); tick();
      store(32'h0000_0004, 4'hF, 32'h2222_2222); tick();
      store(32'h0000_0008, 4'hF, 32'h3333_3333); tick();
      store(32'h0000_0010, 4'hF, 32'h1234_5678); tick();
      store(32'h0000_FFFC, 4'hF, 32'hCAFE_F00D); tick();
      check("preload_store_cnt", {32'd0, store_cnt}, 64'd5);
      check("preload_err", {63'd0, err}, 64'd0);
      reset_pulse();

      // Kseg1 fetch of word 0 returns two consecutive words.
      fetch(32'hA000_0000, 64'h2222_2222_1111_1111); tick();
      check("fetch_cnt_1", {32'd0, fetch_cnt}, 64'd1);
      check("err_after_fetch", {63'd0, err}, 64'd0);

      // Partial-lane store through kseg0, with load data held across the store cycle.
      load(32'h8000_0004, 32'h2222_2222); tick();
      store(32'h8000_0010, 4'b0010, 32'h0000_AB00); tick();
      check("rdata_hold_on_store", {32'd0, data_sram_rdata}, 64'h2222_2222);
      load(32'h8000_0010, 32'h1234_AB78); tick();
      check("store_cnt_1", {32'd0, store_cnt}, 64'd1);
      load(32'h8000_0013, 32'h1234_AB78); tick();
      check("ignore_low_bits_err", {63'd0, err}, 64'd0);

      tick();
      check("idle_inst_hold", inst_sram_rdata, 64'h2222_2222_1111_1111);
      check("idle_data_hold", {32'd0, data_sram_rdata}, 64'h1234_AB78);

      // Top word: high half reads as zero without error.
      fetch(32'h0000_FFFC, 64'h0000_0000_CAFE_F00D); tick();
      check("top_word_err", {63'd0, err}, 64'd0);

      // Same-cycle store and fetch of word 0: fetch sees the old value, the next fetch the new one.
      store(32'h0000_0000, 4'hF, 32'hDEAD_BEEF);
      fetch(32'h0000_0000, 64'h2222_2222_1111_1111); tick();
      fetch(32'h0000_0000, 64'h2222_2222_DEAD_BEEF); tick();
      check("fetch_cnt_4", {32'd0, fetch_cnt}, 64'd4);
      check("store_cnt_2", {32'd0, store_cnt}, 64'd2);

      // Out-of-range load sets the sticky error; a later misaligned fetch leaves err_addr alone.
      load(32'h0010_0000, 32'h0); tick();
      check("oor_err", {63'd0, err}, 64'd1);
      check("oor_err_addr", {32'd0, err_addr}, 64'h0010_0000);
      fetch(32'h0000_0002, 64'h2222_2222_DEAD_BEEF); tick();
      check("sticky_err_addr", {32'd0, err_addr}, 64'h0010_0000);
      check("fetch_cnt_5", {32'd0, fetch_cnt}, 64'd5);

      // Out-of-range store is counted but dropped (it must not alias onto word 0).
      store(32'h0010_0000, 4'hF, 32'h5555_5555); tick();
      check("store_cnt_3", {32'd0, store_cnt}, 64'd3);
      load(32'h0000_0000, 32'hDEAD_BEEF); tick();

      // Reset asserted mid-burst: outputs clear at once, memory survives.
      fetch(32'h0000_0000, 64'h0); inst_q.delete();
      load(32'h0000_0004, 32'h0); data_q.delete();
      @(posedge clk);
      #3 resetn = 1'b0;
      #1 check_all_zero("mid_burst");
      idle_inputs();
      @(posedge clk);
      #1 resetn = 1'b1;
      load(32'h0000_0000, 32'hDEAD_BEEF); tick();
      check("post_reset_err", {63'd0, err}, 64'd0);

      // A write attempt on the instruction port is an error and writes nothing.
      inst_sram_en = 1'b1; inst_sram_wen = 4'hF; inst_sram_addr = 32'h0000_0004;
      inst_sram_wdata = 32'hFFFF_FFFF; tick();
      check("inst_wen_err", {63'd0, err}, 64'd1);
      check("inst_wen_err_addr", {32'd0, err_addr}, 64'h0000_0004);
      load(32'h0000_0004, 32'h2222_2222); tick();
      reset_pulse();

      // Both ports erroring in one cycle: the data address wins.
      fetch(32'h0000_0001, 64'h2222_2222_DEAD_BEEF);
      load(32'h0020_0000, 32'h0); tick();
      check("dual_err", {63'd0, err}, 64'd1);
      check("dual_err_addr", {32'd0, err_addr}, 64'h0020_0000);

      check("inst_queue_drained", 64'(inst_q.size()), 64'd0);
      check("data_queue_drained", 64'(data_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
